puf_challenge_sequencer: RTL and testbench

- Sequences one challenge-generation campaign for the delay-based PUF.
- Drives the increment input of the scrambler LFSR one step at a time, and presents the seed on the scrambler's challenge input.
- For each scrambled challenge, launches one PUF evaluation, waits for the result, then streams out the challenge/response pair over a valid/ready handshake.
- Sits between the top-level command logic (UART/serial side) and the scrambler + RO PUF core.

---
 rtl/puf_challenge_sequencer.sv | 175 +++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
// Runs one challenge-generation campaign for the delay-based PUF: steps the
// scrambler LFSR, launches one PUF evaluation per scrambled challenge, waits
// for the response and streams each challenge/response pair out over a
// valid/ready handshake. Sits between the command logic and the scrambler +
// RO PUF core.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for start; done pulses here for one cycle after FIN
// STEP   | scr_increment high for one cycle
// SETTLE | registered scrambler output catches up with the step
// EVAL   | challenge captured, puf_start high for one cycle, timer loaded
// WAIT   | waiting for puf_done; timer counts down to the timeout
// OUT    | pair presented on resp_*, held until resp_ready
// FIN    | campaign over; done is raised on the way back to IDLE

module puf_challenge_sequencer #(
    parameter int CNT_W          = 8,
    // Cycles from puf_start to the done pulse of a timed-out campaign.
    // Must be at least 3.
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       seed,
    input  logic [CNT_W-1:0] num_chall,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [7:0]       scr_chall_in,
    output logic             scr_increment,
    input  logic [7:0]       scr_chall_out,
    output logic             puf_start,
    input  logic             puf_done,
    input  logic             puf_resp,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_chall,
    output logic             resp_bit,
    output logic [CNT_W-1:0] resp_idx
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    // The timer is a down-counter loaded in EVAL. It hits zero in the last
    // WAIT cycle, which is the cycle where the elapsed count since puf_start
    // reaches TIMEOUT_CYCLES-1 on its next step. puf_done in that cycle
    // still wins over the timeout.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 3);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_EVAL,
        S_WAIT,
        S_OUT,
        S_FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] num_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] idx_inc;

    // resp_idx doubles as the issued-challenge counter; it wraps naturally.
    assign idx_inc = resp_idx + IDX_ONE;

    // Campaign sequencing; every output is registered and pulses default low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            num_q         <= '0;
            tmo_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            scr_chall_in  <= '0;
            scr_increment <= 1'b0;
            puf_start     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_chall    <= '0;
            resp_bit      <= 1'b0;
            resp_idx      <= '0;
        end else begin
            scr_increment <= 1'b0;
            puf_start     <= 1'b0;
            done          <= 1'b0;

            if (abort && (state != S_IDLE)) begin
                // Abort ends the campaign silently; timeout_err is left alone.
                state      <= S_IDLE;
                busy       <= 1'b0;
                resp_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            scr_chall_in <= seed;
                            num_q        <= num_chall;
                            timeout_err  <= 1'b0;
                            resp_idx     <= '0;
                            busy         <= 1'b1;
                            if (num_chall == '0) begin
                                state <= S_FIN;
                            end else begin
                                state         <= S_STEP;
                                scr_increment <= 1'b1;
                            end
                        end
                    end

                    S_STEP: begin
                        state <= S_SETTLE;
                    end

                    S_SETTLE: begin
                        state     <= S_EVAL;
                        puf_start <= 1'b1;
                    end

                    S_EVAL: begin
                        resp_chall <= scr_chall_out;
                        tmo_cnt    <= TMO_LOAD;
                        state      <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (puf_done) begin
                            resp_bit   <= puf_resp;
                            resp_valid <= 1'b1;
                            state      <= S_OUT;
                        end else if (tmo_cnt == '0) begin
                            timeout_err <= 1'b1;
                            state       <= S_FIN;
                        end else begin
                            tmo_cnt <= tmo_cnt - TMO_ONE;
                        end
                    end

                    S_OUT: begin
                        if (resp_ready) begin
                            resp_valid <= 1'b0;
                            resp_idx   <= idx_inc;
                            if (idx_inc == num_q) begin
                                state <= S_FIN;
                            end else begin
                                state         <= S_STEP;
                                scr_increment <= 1'b1;
                            end
                        end
                    end

                    S_FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        resp_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with a toy scrambler
// (k-th step after a clear gives chall_in ^ (k * 8'h1D)) and a PUF model
// that answers 10 cycles after puf_start with resp = launch count bit 0.

module tb_puf_challenge_sequencer;

    localparam int CNT_W = 8;
    localparam int TMO   = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [7:0]       seed;
    logic [CNT_W-1:0] num_chall;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [7:0]       scr_chall_in;
    logic             scr_increment;
    logic [7:0]       scr_chall_out;
    logic             puf_start;
    logic             puf_done;
    logic             puf_resp;
    logic             resp_valid;
    logic             resp_ready;
    logic [7:0]       resp_chall;
    logic             resp_bit;
    logic [CNT_W-1:0] resp_idx;

    logic             tb_clear;
    logic             puf_en;
    logic [7:0]       scr_steps;
    logic [3:0]       puf_timer;
    logic [7:0]       puf_seq;

    int n_inc, n_pst, n_done, n_pair;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    puf_challenge_sequencer #(
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .seed(seed),
        .num_chall(num_chall),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err),
        .scr_chall_in(scr_chall_in),
        .scr_increment(scr_increment),
        .scr_chall_out(scr_chall_out),
        .puf_start(puf_start),
        .puf_done(puf_done),
        .puf_resp(puf_resp),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_chall(resp_chall),
        .resp_bit(resp_bit),
        .resp_idx(resp_idx)
    );

    // Scrambler model: registered output, one step per scr_increment.
    always @(posedge clock) begin
        if (tb_clear) begin
            scr_steps     <= 8'd0;
            scr_chall_out <= 8'd0;
        end else if (scr_increment) begin
            scr_steps     <= scr_steps + 8'd1;
            scr_chall_out <= scr_chall_in ^ ((scr_steps + 8'd1) * 8'h1D);
        end
    end

    // PUF model: done strobe 10 cycles after launch, response = launch count bit 0.
    always @(posedge clock) begin
        if (tb_clear) begin
            puf_timer <= 4'd0;
            puf_seq   <= 8'd0;
            puf_resp  <= 1'b0;
        end else if (puf_start && puf_en) begin
            puf_timer <= 4'd10;
            puf_resp  <= puf_seq[0];
            puf_seq   <= puf_seq + 8'd1;
        end else if (puf_timer != 4'd0) begin
            puf_timer <= puf_timer - 4'd1;
        end
    end
    assign puf_done = (puf_timer == 4'd1);

    // Pulse and handshake counters since the last clear.
    always @(posedge clock) begin
        if (tb_clear) begin
            n_inc  <= 0;
            n_pst  <= 0;
            n_done <= 0;
            n_pair <= 0;
        end else begin
            if (scr_increment)             n_inc  <= n_inc + 1;
            if (puf_start)                 n_pst  <= n_pst + 1;
            if (done)                      n_done <= n_done + 1;
            if (resp_valid && resp_ready)  n_pair <= n_pair + 1;
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pair(input string tag, input logic [7:0] ch, input logic b, input logic [7:0] ix);
        chk(tag, {15'd0, resp_chall, resp_bit, resp_idx}, {15'd0, ch, b, ix});
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!resp_valid && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic wait_pst(input string tag);
        int n = 0;
        while (!puf_start && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, puf_start}, 32'd1);
    endtask

    task automatic clear_models();
        tb_clear = 1'b1;
        tick();
        tb_clear = 1'b0;
    endtask

    logic        idle_ok;
    logic        bp_ok;
    logic [16:0] snap;
    logic [7:0]  kk;

    initial begin
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        seed = 8'h00;
        num_chall = '0;
        resp_ready = 1'b0;
        tb_clear = 1'b1;
        puf_en = 1'b1;
        tick();
        tick();

        // Reset with start held high
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {26'd0, done, timeout_err, scr_increment, puf_start, resp_valid, resp_bit}, 32'd0);
        chk("rst_chall_in", {24'd0, scr_chall_in}, 32'd0);
        chk("rst_resp", {16'd0, resp_chall, resp_idx}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tb_clear = 1'b0;
        idle_ok = 1'b1;
        repeat (5) begin
            tick();
            if (busy || scr_increment || puf_start || done || resp_valid) idle_ok = 1'b0;
        end
        chk("idle_5cyc", {31'd0, idle_ok}, 32'd1);

        // Normal campaign, seed A5, 3 challenges
        seed = 8'hA5;
        num_chall = 8'd3;
        resp_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("n_busy", {31'd0, busy}, 32'd1);
        chk("n_inc_n1", {31'd0, scr_increment}, 32'd1);
        chk("n_chall_in", {24'd0, scr_chall_in}, 32'hA5);
        tick();
        chk("n_pst_n2", {31'd0, puf_start}, 32'd0);
        tick();
        chk("n_pst_n3", {31'd0, puf_start}, 32'd1);

        wait_valid("n_p0_valid");
        chk_pair("n_p0", 8'hB8, 1'b0, 8'd0);
        tick();
        chk("n_inc_after_hs0", {31'd0, scr_increment}, 32'd1);
        resp_ready = 1'b0;

        // Backpressure on pair 1
        wait_valid("n_p1_valid");
        chk_pair("n_p1", 8'h9F, 1'b1, 8'd1);
        snap = {resp_chall, resp_bit, resp_idx};
        bp_ok = 1'b1;
        repeat (20) begin
            tick();
            if (!resp_valid || ({resp_chall, resp_bit, resp_idx} !== snap) || scr_increment) bp_ok = 1'b0;
        end
        chk("bp_hold", {31'd0, bp_ok}, 32'd1);
        resp_ready = 1'b1;
        tick();
        chk("bp_inc_after_hs", {31'd0, scr_increment}, 32'd1);

        wait_valid("n_p2_valid");
        chk_pair("n_p2", 8'hF2, 1'b0, 8'd2);
        tick();
        chk("n_fin_nodone", {31'd0, done}, 32'd0);
        tick();
        chk("n_done", {31'd0, done}, 32'd1);
        chk("n_busy_end", {31'd0, busy}, 32'd0);
        tick();
        chk("n_done_pulse", {31'd0, done}, 32'd0);
        chk("n_inc_cnt", n_inc, 32'd3);
        chk("n_pst_cnt", n_pst, 32'd3);
        chk("n_pair_cnt", n_pair, 32'd3);
        chk("n_done_cnt", n_done, 32'd1);
        chk("n_terr", {31'd0, timeout_err}, 32'd0);

        // Timeout: PUF never answers
        clear_models();
        puf_en = 1'b0;
        seed = 8'h3C;
        num_chall = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t_pst", {31'd0, puf_start}, 32'd1);
        repeat (13) tick();
        chk("t_err_p13", {31'd0, timeout_err}, 32'd0);
        chk("t_busy_p13", {31'd0, busy}, 32'd1);
        tick();
        tick();
        chk("t_nodone_p15", {31'd0, done}, 32'd0);
        tick();
        chk("t_done_p16", {31'd0, done}, 32'd1);
        chk("t_err_p16", {31'd0, timeout_err}, 32'd1);
        tick();
        chk("t_done_once", {31'd0, done}, 32'd0);
        chk("t_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("t_pair_cnt", n_pair, 32'd0);
        chk("t_inc_cnt", n_inc, 32'd1);

        // num_chall = 0, also clears timeout_err
        clear_models();
        puf_en = 1'b1;
        seed = 8'h11;
        num_chall = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("z_err_clr", {31'd0, timeout_err}, 32'd0);
        chk("z_nodone_n1", {31'd0, done}, 32'd0);
        chk("z_chall_in", {24'd0, scr_chall_in}, 32'h11);
        tick();
        chk("z_done_n2", {31'd0, done}, 32'd1);
        tick();
        chk("z_inc_cnt", n_inc, 32'd0);
        chk("z_pst_cnt", n_pst, 32'd0);
        chk("z_done_cnt", n_done, 32'd1);

        // Abort in WAIT on challenge 2 of 5, with an ignored start earlier
        clear_models();
        seed = 8'h5A;
        num_chall = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        seed = 8'hFF;
        num_chall = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("a_p0_valid");
        chk_pair("a_p0", 8'h47, 1'b0, 8'd0);
        tick();
        wait_valid("a_p1_valid");
        chk_pair("a_p1", 8'h60, 1'b1, 8'd1);
        tick();
        wait_pst("a_p2_launch");
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_busy", {31'd0, busy}, 32'd0);
        chk("a_novalid", {31'd0, resp_valid}, 32'd0);
        chk("a_chall_in", {24'd0, scr_chall_in}, 32'h5A);
        repeat (12) tick();
        chk("a_still_idle", {31'd0, busy}, 32'd0);
        chk("a_done_cnt", n_done, 32'd0);
        chk("a_pst_cnt", n_pst, 32'd3);

        // Restart after abort: full 5-pair run
        clear_models();
        seed = 8'hC3;
        num_chall = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            kk = 8'(k);
            wait_valid("r_valid");
            chk_pair("r_pair", 8'hC3 ^ ((kk + 8'd1) * 8'h1D), kk[0], kk);
            tick();
        end
        tick();
        chk("r_done", {31'd0, done}, 32'd1);
        tick();
        chk("r_inc_cnt", n_inc, 32'd5);
        chk("r_pair_cnt", n_pair, 32'd5);
        chk("r_done_cnt", n_done, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
